// File: rtl/se_lookup_arbiter.sv
// Round-robin arbiter sharing one MAC search engine among NREQ frame-process ports.

// Two-entry request queue with drop-on-full push and simultaneous push/pop.
// Latency: a push is visible at rd_dat/empty on the next cycle.
// Backpressure: none upstream; pushes into a full queue are discarded (full tells the caller).
module se_lookup_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_wr;
  logic         do_rd;

  assign full   = (cnt == 2'd2);
  assign empty  = (cnt == 2'd0);
  assign do_wr  = wr_en & ~full;
  assign do_rd  = rd_en & ~empty;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_wr) wr_ptr <= ~wr_ptr;
      if (do_rd) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_wr} - {1'b0, do_rd};
    end
  end
endmodule

// Queues per-port lookups and serialises them onto one search engine, round-robin.
// Latency: req pulse t -> se_req t+2; engine ack/nak k -> port ack/nak k+1; one lookup in flight.
// Backpressure: 2-deep queue per port; a request to a full queue is dropped and flagged in arb_ovf.
module se_lookup_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_se_req,
  input  logic [NREQ*48-1:0] req_se_mac,
  input  logic [NREQ*10-1:0] req_se_hash,
  input  logic [NREQ-1:0]   req_se_source,
  input  logic [NREQ*16-1:0] req_source_portmap,
  output logic [NREQ-1:0]   req_se_ack,
  output logic [NREQ-1:0]   req_se_nak,
  output logic [15:0]       req_se_result,
  output logic              se_req,
  output logic [47:0]       se_mac,
  output logic [9:0]        se_hash,
  output logic              se_source,
  output logic [15:0]       source_portmap,
  input  logic              se_ack,
  input  logic              se_nak,
  input  logic [15:0]       se_result,
  output logic [NREQ-1:0]   arb_ovf,
  input  logic              arb_ovf_clr
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic [47:0] mac;
    logic [9:0]  hash;
    logic        source;
    logic [15:0] portmap;
  } hdr_t;

  localparam int HW = $bits(hdr_t);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_WAIT  = 4'b0100,
    S_RESP  = 4'b1000
  } state_t;

  state_t          state;
  state_t          nxt;
  hdr_t            q_in   [NREQ];
  hdr_t            q_head [NREQ];
  logic [NREQ-1:0] q_full;
  logic [NREQ-1:0] q_empty;
  logic [NREQ-1:0] q_pop;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   grant;
  logic [NREQ-1:0] grant_oh;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [7:0]      tmo_cnt;
  logic            tmo_hit;
  logic            resp_nak;

  for (genvar i = 0; i < NREQ; i++) begin : g_port
    assign q_in[i] = {req_se_mac[i*48 +: 48], req_se_hash[i*10 +: 10],
                      req_se_source[i], req_source_portmap[i*16 +: 16]};

    se_lookup_fifo #(.W(HW)) u_q (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (req_se_req[i]),
      .wr_dat (q_in[i]),
      .rd_en  (q_pop[i]),
      .rd_dat (q_head[i]),
      .full   (q_full[i]),
      .empty  (q_empty[i])
    );
  end

  assign grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant;
  assign tmo_hit  = (tmo_cnt == 8'(TIMEOUT));

  // Scan from rr_ptr+1 upward; descending loop lets the nearest candidate win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (!q_empty[(int'(rr_ptr) + k) % NREQ]) begin
        pick_vld = 1'b1;
        pick_idx = IW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (pick_vld) nxt = S_ISSUE;
      S_ISSUE: nxt = S_WAIT;
      S_WAIT:  if (se_ack || se_nak || tmo_hit) nxt = S_RESP;
      S_RESP:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    se_req     = 1'b0;
    q_pop      = '0;
    req_se_ack = '0;
    req_se_nak = '0;
    unique case (state)
      S_ISSUE: begin
        se_req = 1'b1;
        q_pop  = grant_oh;
      end
      S_RESP: begin
        if (resp_nak) req_se_nak = grant_oh;
        else          req_se_ack = grant_oh;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant          <= '0;
      rr_ptr         <= '0;
      se_mac         <= '0;
      se_hash        <= '0;
      se_source      <= 1'b0;
      source_portmap <= '0;
      tmo_cnt        <= '0;
      resp_nak       <= 1'b0;
      req_se_result  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant <= pick_idx;
            {se_mac, se_hash, se_source, source_portmap} <= q_head[pick_idx];
          end
        end
        S_ISSUE: tmo_cnt <= '0;
        S_WAIT: begin
          // nak outranks ack; a timeout reports as a nak with a zero result
          if (se_nak) begin
            resp_nak      <= 1'b1;
            req_se_result <= se_result;
          end else if (se_ack) begin
            resp_nak      <= 1'b0;
            req_se_result <= se_result;
          end else if (tmo_hit) begin
            resp_nak      <= 1'b1;
            req_se_result <= 16'h0000;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_RESP: rr_ptr <= grant;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) arb_ovf <= '0;
    else     arb_ovf <= (arb_ovf & ~{NREQ{arb_ovf_clr}}) | (req_se_req & q_full);
  end
endmodule

// File: tb/tb_se_lookup_arbiter.sv
// Self-checking bench for se_lookup_arbiter: directed scenarios plus a randomized run against a queue model.
module tb_se_lookup_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 63;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_se_req;
  logic [NREQ*48-1:0] req_se_mac;
  logic [NREQ*10-1:0] req_se_hash;
  logic [NREQ-1:0]   req_se_source;
  logic [NREQ*16-1:0] req_source_portmap;
  logic [NREQ-1:0]   req_se_ack;
  logic [NREQ-1:0]   req_se_nak;
  logic [15:0]       req_se_result;
  logic              se_req;
  logic [47:0]       se_mac;
  logic [9:0]        se_hash;
  logic              se_source;
  logic [15:0]       source_portmap;
  logic              se_ack;
  logic              se_nak;
  logic [15:0]       se_result;
  logic [NREQ-1:0]   arb_ovf;
  logic              arb_ovf_clr;

  always #5 clk = ~clk;

  se_lookup_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_se_req(req_se_req), .req_se_mac(req_se_mac), .req_se_hash(req_se_hash),
    .req_se_source(req_se_source), .req_source_portmap(req_source_portmap),
    .req_se_ack(req_se_ack), .req_se_nak(req_se_nak), .req_se_result(req_se_result),
    .se_req(se_req), .se_mac(se_mac), .se_hash(se_hash), .se_source(se_source),
    .source_portmap(source_portmap), .se_ack(se_ack), .se_nak(se_nak),
    .se_result(se_result), .arb_ovf(arb_ovf), .arb_ovf_clr(arb_ovf_clr)
  );

  typedef struct {
    int          cyc;
    int          port;
    logic [47:0] mac;
    logic [9:0]  hash;
    logic        src;
    logic [15:0] pm;
  } stim_t;

  int errors = 0;
  int checks = 0;
  int gcyc   = 0;
  int base   = 0;

  stim_t       stim_q[$];
  int          req_cyc[$];
  logic [74:0] req_fld[$];
  int          rsp_cyc[$];
  int          rsp_port[$];
  logic        rsp_nak[$];
  logic [15:0] rsp_res[$];
  int          exp_cyc[$];
  logic        exp_nak[$];
  logic [15:0] exp_res[$];
  int          bad_pulse;
  int          due_cyc;
  logic        due_ack;
  logic        due_nak;
  logic [15:0] due_res;

  task automatic tick();
    @(posedge clk);
    #1;
    gcyc++;
  endtask

  task automatic drive_idle();
    req_se_req = '0; req_se_mac = '0; req_se_hash = '0;
    req_se_source = '0; req_source_portmap = '0;
    se_ack = 1'b0; se_nak = 1'b0; se_result = 16'hDEAD; arb_ovf_clr = 1'b0;
  endtask

  task automatic clear_rec();
    stim_q.delete(); req_cyc.delete(); req_fld.delete();
    rsp_cyc.delete(); rsp_port.delete(); rsp_nak.delete(); rsp_res.delete();
    exp_cyc.delete(); exp_nak.delete(); exp_res.delete();
    bad_pulse = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    due_cyc = -1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic stim_t mk(input int c, input int p, input logic [47:0] m,
                               input logic [9:0] h, input logic s, input logic [15:0] pm);
    stim_t e;
    e.cyc = c; e.port = p; e.mac = m; e.hash = h; e.src = s; e.pm = pm;
    return e;
  endfunction

  // Engine: delay<0 never answers; mode 0 ack, 1 nak, 2 both. noise pokes ack during ISSUE.
  task automatic run(input int n, input int delay, input int mode, input logic [15:0] res,
                     input bit rnd, input bit noise, input int clr_cyc);
    int d, m, p, ones;
    logic [15:0] r;
    logic sreq;
    logic [NREQ-1:0] any;
    base = gcyc;
    for (int c = 0; c < n; c++) begin
      sreq = se_req;
      if (sreq) begin
        req_cyc.push_back(gcyc);
        req_fld.push_back({se_mac, se_hash, se_source, source_portmap});
        d = delay; m = mode; r = res;
        if (rnd) begin
          d = int'($urandom_range(1, 6));
          m = int'($urandom_range(0, 2));
          r = 16'($urandom);
        end
        if (d < 0) begin
          due_cyc = -1;
          exp_cyc.push_back(gcyc + TIMEOUT + 2); exp_nak.push_back(1'b1); exp_res.push_back(16'h0);
        end else begin
          due_cyc = gcyc + d; due_ack = (m != 1); due_nak = (m != 0); due_res = r;
          exp_cyc.push_back(gcyc + d + 1); exp_nak.push_back(m != 0); exp_res.push_back(r);
        end
      end
      any = req_se_ack | req_se_nak;
      if (any != '0) begin
        ones = 0; p = -1;
        for (int i = 0; i < NREQ; i++) if (any[i]) begin ones++; p = i; end
        if (ones != 1 || (req_se_ack & req_se_nak) != '0) bad_pulse++;
        rsp_cyc.push_back(gcyc); rsp_port.push_back(p);
        rsp_nak.push_back(req_se_nak != '0); rsp_res.push_back(req_se_result);
      end
      drive_idle();
      foreach (stim_q[i]) begin
        if (stim_q[i].cyc == c) begin
          p = stim_q[i].port;
          req_se_req[p] = 1'b1;
          req_se_mac[p*48 +: 48] = stim_q[i].mac;
          req_se_hash[p*10 +: 10] = stim_q[i].hash;
          req_se_source[p] = stim_q[i].src;
          req_source_portmap[p*16 +: 16] = stim_q[i].pm;
        end
      end
      arb_ovf_clr = (c == clr_cyc);
      if (gcyc == due_cyc) begin
        se_ack = due_ack; se_nak = due_nak; se_result = due_res;
      end
      if (noise && sreq) begin
        se_ack = 1'b1; se_result = 16'hFFFF;
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #2;
    checks++;
    if ({se_req, se_mac, se_hash, se_source, source_portmap} !== '0) begin
      errors++; $display("FAIL reset_engine_outputs: got %h want 0", {se_req, se_mac, se_hash, se_source, source_portmap});
    end
    checks++;
    if ({req_se_ack, req_se_nak, req_se_result, arb_ovf} !== '0) begin
      errors++; $display("FAIL reset_port_outputs: got %h want 0", {req_se_ack, req_se_nak, req_se_result, arb_ovf});
    end
    due_cyc = -1;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (se_req !== 1'b0) begin errors++; $display("FAIL reset_idle_se_req: got %b want 0", se_req); end
      tick();
    end
  endtask

  task automatic test_latency();
    logic [47:0] m;
    m = 48'h0011_2233_4455;
    do_reset(); clear_rec();
    stim_q.push_back(mk(0, 0, m, 10'h155, 1'b0, 16'h0001));
    run(20, 3, 0, 16'h0004, 0, 0, -1);
    checks++;
    if (req_cyc.size() != 1) begin
      errors++; $display("FAIL t1_req_count: got %0d want 1", req_cyc.size());
    end else begin
      checks++;
      if (req_cyc[0] - base != 2) begin errors++; $display("FAIL t1_se_req_cycle: got %0d want 2", req_cyc[0] - base); end
      checks++;
      if (req_fld[0] !== {m, 10'h155, 1'b0, 16'h0001}) begin errors++; $display("FAIL t1_fields: got %h want %h", req_fld[0], {m, 10'h155, 1'b0, 16'h0001}); end
    end
    checks++;
    if (rsp_cyc.size() != 1) begin
      errors++; $display("FAIL t1_rsp_count: got %0d want 1", rsp_cyc.size());
    end else begin
      checks++;
      if (rsp_cyc[0] - base != 6) begin errors++; $display("FAIL t1_ack_cycle: got %0d want 6", rsp_cyc[0] - base); end
      checks++;
      if (rsp_port[0] != 0 || rsp_nak[0] !== 1'b0) begin errors++; $display("FAIL t1_ack_port: got port %0d nak %b want port 0 nak 0", rsp_port[0], rsp_nak[0]); end
      checks++;
      if (rsp_res[0] !== 16'h0004) begin errors++; $display("FAIL t1_result: got %h want 0004", rsp_res[0]); end
    end
    checks++;
    if (req_se_result !== 16'h0004) begin errors++; $display("FAIL t1_result_hold: got %h want 0004", req_se_result); end
  endtask

  task automatic test_round_robin();
    int cnt;
    do_reset(); clear_rec();
    for (int p = 0; p < NREQ; p++)
      stim_q.push_back(mk(0, p, 48'hA0 + 48'(p), 10'(p + 1), p[0], 16'h1 << p));
    run(30, 1, 0, 16'h0100, 0, 0, -1);
    checks++;
    if (rsp_cyc.size() != NREQ || req_cyc.size() != NREQ) begin
      errors++; $display("FAIL t2_count: got req %0d rsp %0d want %0d", req_cyc.size(), rsp_cyc.size(), NREQ);
    end else begin
      for (int j = 0; j < NREQ; j++) begin
        checks++;
        if (rsp_port[j] != (j + 1) % NREQ || req_fld[j][74:27] !== 48'hA0 + 48'((j + 1) % NREQ)) begin
          errors++; $display("FAIL t2_order[%0d]: got port %0d mac %h want port %0d", j, rsp_port[j], req_fld[j][74:27], (j + 1) % NREQ);
        end
        if (j > 0) begin
          checks++;
          if (req_cyc[j] - req_cyc[j-1] != 4) begin errors++; $display("FAIL t2_spacing[%0d]: got %0d want 4", j, req_cyc[j] - req_cyc[j-1]); end
        end
      end
      for (int p = 0; p < NREQ; p++) begin
        cnt = 0;
        foreach (rsp_port[j]) if (rsp_port[j] == p && rsp_nak[j] == 1'b0) cnt++;
        checks++;
        if (cnt != 1) begin errors++; $display("FAIL t2_acks_port%0d: got %0d want 1", p, cnt); end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset(); clear_rec();
    stim_q.push_back(mk(0, 2, 48'hC0, 10'h001, 1'b0, 16'h0004));
    stim_q.push_back(mk(6, 2, 48'hC1, 10'h002, 1'b1, 16'h0004));
    stim_q.push_back(mk(7, 2, 48'hC2, 10'h003, 1'b0, 16'h0004));
    stim_q.push_back(mk(8, 2, 48'hC3, 10'h004, 1'b1, 16'h0004));
    run(15, 20, 0, 16'h0020, 0, 0, -1);
    checks++;
    if (arb_ovf !== 4'b0100) begin errors++; $display("FAIL t3_ovf_set: got %b want 0100", arb_ovf); end
    stim_q.delete();
    stim_q.push_back(mk(0, 2, 48'hC4, 10'h005, 1'b0, 16'h0004));
    run(1, 20, 0, 16'h0020, 0, 0, 0);
    checks++;
    if (arb_ovf !== 4'b0100) begin errors++; $display("FAIL t3_ovf_clr_vs_set: got %b want 0100", arb_ovf); end
    stim_q.delete();
    run(1, 20, 0, 16'h0020, 0, 0, 0);
    checks++;
    if (arb_ovf !== 4'b0000) begin errors++; $display("FAIL t3_ovf_clr: got %b want 0000", arb_ovf); end
    run(120, 20, 0, 16'h0020, 0, 0, -1);
    checks++;
    if (req_fld.size() != 3 || rsp_cyc.size() != 3) begin
      errors++; $display("FAIL t3_count: got req %0d rsp %0d want 3", req_fld.size(), rsp_cyc.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (req_fld[j][74:27] !== 48'hC0 + 48'(j) || rsp_port[j] != 2 || rsp_nak[j] !== 1'b0) begin
          errors++; $display("FAIL t3_fifo_order[%0d]: got mac %h port %0d want mac %h port 2", j, req_fld[j][74:27], rsp_port[j], 48'hC0 + 48'(j));
        end
      end
    end
  endtask

  task automatic test_timeout();
    do_reset(); clear_rec();
    stim_q.push_back(mk(0, 0, 48'hD0, 10'h010, 1'b0, 16'h0001));
    stim_q.push_back(mk(1, 3, 48'hD3, 10'h013, 1'b1, 16'h0008));
    run(140, -1, 0, 16'h0, 0, 0, -1);
    checks++;
    if (rsp_cyc.size() != 2 || req_cyc.size() != 2) begin
      errors++; $display("FAIL t4_count: got req %0d rsp %0d want 2", req_cyc.size(), rsp_cyc.size());
    end else begin
      checks++;
      if (rsp_cyc[0] - req_cyc[0] != TIMEOUT + 2) begin errors++; $display("FAIL t4_nak_cycle: got %0d want %0d", rsp_cyc[0] - req_cyc[0], TIMEOUT + 2); end
      checks++;
      if (rsp_nak[0] !== 1'b1 || rsp_port[0] != 0 || rsp_res[0] !== 16'h0) begin
        errors++; $display("FAIL t4_nak: got nak %b port %0d res %h want nak 1 port 0 res 0000", rsp_nak[0], rsp_port[0], rsp_res[0]);
      end
      checks++;
      if (rsp_port[1] != 3 || req_cyc[1] - base != TIMEOUT + 6) begin
        errors++; $display("FAIL t4_next_port: got port %0d at %0d want port 3 at %0d", rsp_port[1], req_cyc[1] - base, TIMEOUT + 6);
      end
    end
  endtask

  task automatic test_ack_nak_both();
    do_reset(); clear_rec();
    stim_q.push_back(mk(0, 1, 48'hE1, 10'h021, 1'b0, 16'h0002));
    run(15, 2, 2, 16'h000A, 0, 1, -1);
    checks++;
    if (rsp_cyc.size() != 1) begin
      errors++; $display("FAIL t5_count: got %0d want 1", rsp_cyc.size());
    end else begin
      checks++;
      if (rsp_nak[0] !== 1'b1 || rsp_port[0] != 1 || rsp_res[0] !== 16'h000A) begin
        errors++; $display("FAIL t5_nak_wins: got nak %b port %0d res %h want nak 1 port 1 res 000a", rsp_nak[0], rsp_port[0], rsp_res[0]);
      end
      checks++;
      if (rsp_cyc[0] - base != 5) begin errors++; $display("FAIL t5_issue_ack_ignored: got cycle %0d want 5", rsp_cyc[0] - base); end
    end
    checks++;
    if (bad_pulse != 0) begin errors++; $display("FAIL t5_single_pulse: got %0d bad pulses want 0", bad_pulse); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset(); clear_rec();
    stim_q.push_back(mk(0, 1, 48'hF1, 10'h031, 1'b0, 16'h0002));
    stim_q.push_back(mk(1, 3, 48'hF3, 10'h033, 1'b0, 16'h0008));
    stim_q.push_back(mk(2, 3, 48'hF4, 10'h034, 1'b1, 16'h0008));
    run(10, -1, 0, 16'h0, 0, 0, -1);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({se_req, se_mac, se_hash, se_source, source_portmap, req_se_ack, req_se_nak, req_se_result, arb_ovf} !== '0) begin
      errors++; $display("FAIL t6_outputs_in_reset: got %h want 0", {se_req, se_mac, se_hash, se_source, source_portmap, req_se_ack, req_se_nak, req_se_result, arb_ovf});
    end
    due_cyc = -1;
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      se_ack = (c < 3); se_result = 16'h1234;
      checks++;
      if ({se_req, req_se_ack, req_se_nak} !== '0) begin
        errors++; $display("FAIL t6_quiet_after_reset[%0d]: got %b want 0", c, {se_req, req_se_ack, req_se_nak});
      end
      tick();
    end
    drive_idle(); clear_rec();
    stim_q.push_back(mk(0, 2, 48'hF2, 10'h032, 1'b1, 16'h0004));
    run(12, 1, 0, 16'h0777, 0, 0, -1);
    checks++;
    if (req_cyc.size() != 1 || rsp_cyc.size() != 1) begin
      errors++; $display("FAIL t6_count: got req %0d rsp %0d want 1", req_cyc.size(), rsp_cyc.size());
    end else begin
      checks++;
      if (rsp_port[0] != 2 || rsp_nak[0] !== 1'b0 || rsp_res[0] !== 16'h0777 || req_cyc[0] - base != 2) begin
        errors++; $display("FAIL t6_new_request: got port %0d nak %b res %h cyc %0d want port 2 nak 0 res 0777 cyc 2", rsp_port[0], rsp_nak[0], rsp_res[0], req_cyc[0] - base);
      end
    end
  endtask

  task automatic test_random();
    stim_t mq[$];
    logic [NREQ-1:0] ovf_exp;
    int si, j, rr, gp, gi, cnt, idx;
    do_reset(); clear_rec();
    for (int c = 0; c < 200; c++)
      for (int p = 0; p < NREQ; p++)
        if ($urandom_range(0, 7) == 0)
          stim_q.push_back(mk(c, p, {16'($urandom), 32'($urandom)}, 10'($urandom), 1'($urandom), 16'($urandom)));
    run(450, 0, 0, 16'h0, 1, 0, -1);
    ovf_exp = '0; si = 0; j = 0; rr = 0;
    for (int t = 0; t < 450; t++) begin
      while (si < stim_q.size() && stim_q[si].cyc == t) begin
        cnt = 0;
        foreach (mq[k]) if (mq[k].port == stim_q[si].port) cnt++;
        if (cnt >= 2) ovf_exp[stim_q[si].port] = 1'b1;
        else mq.push_back(stim_q[si]);
        si++;
      end
      if (j < req_cyc.size() && req_cyc[j] - base == t) begin
        gp = -1; gi = -1;
        for (int k = 1; k <= NREQ; k++) begin
          idx = (rr + k) % NREQ;
          if (gp < 0) begin
            for (int e = mq.size() - 1; e >= 0; e--) if (mq[e].port == idx) gi = e;
            if (gi >= 0 && mq[gi].cyc <= t - 2) gp = idx;
            else gi = -1;
          end
        end
        checks++;
        if (gp < 0) begin
          errors++; $display("FAIL rnd_grant_unexpected[%0d]: se_req at %0d with no eligible entry", j, t);
        end else begin
          checks++;
          if (req_fld[j] !== {mq[gi].mac, mq[gi].hash, mq[gi].src, mq[gi].pm} || j >= rsp_port.size() || rsp_port[j] != gp) begin
            errors++; $display("FAIL rnd_grant[%0d]: got fields %h want %h from port %0d", j, req_fld[j], {mq[gi].mac, mq[gi].hash, mq[gi].src, mq[gi].pm}, gp);
          end
          mq.delete(gi);
          rr = gp;
        end
        j++;
      end
    end
    checks++;
    if (mq.size() != 0 || j != req_cyc.size()) begin errors++; $display("FAIL rnd_all_served: got %0d left, %0d/%0d lookups matched", mq.size(), j, req_cyc.size()); end
    checks++;
    if (rsp_cyc.size() != req_cyc.size()) begin
      errors++; $display("FAIL rnd_rsp_count: got %0d want %0d", rsp_cyc.size(), req_cyc.size());
    end else begin
      foreach (rsp_cyc[k]) begin
        checks++;
        if (rsp_cyc[k] != exp_cyc[k] || rsp_nak[k] !== exp_nak[k] || rsp_res[k] !== exp_res[k]) begin
          errors++; $display("FAIL rnd_rsp[%0d]: got cyc %0d nak %b res %h want cyc %0d nak %b res %h", k, rsp_cyc[k], rsp_nak[k], rsp_res[k], exp_cyc[k], exp_nak[k], exp_res[k]);
        end
      end
    end
    checks++;
    if (bad_pulse != 0) begin errors++; $display("FAIL rnd_pulse_shape: got %0d bad pulses want 0", bad_pulse); end
    checks++;
    if (arb_ovf !== ovf_exp) begin errors++; $display("FAIL rnd_ovf: got %b want %b", arb_ovf, ovf_exp); end
    arb_ovf_clr = 1'b1;
    tick();
    arb_ovf_clr = 1'b0;
    checks++;
    if (arb_ovf !== '0) begin errors++; $display("FAIL rnd_ovf_clr: got %b want 0000", arb_ovf); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    rst = 1'b0;
    due_cyc = -1;
    bad_pulse = 0;
    test_reset();
    test_latency();
    test_round_robin();
    test_overflow();
    test_timeout();
    test_ack_nak_both();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
